fifo_dc_wr_arbiter: RTL and testbench
=====================================

// Module: fifo_dc_wr_arbiter
// PURPOSE
//  - Shares the write port of one fifo_dc between two pixel requesters (req0, req1) in the wr_clock domain.
//  - Grants bursts of up to BURST_LEN words; round-robin between requesters.
//  - Tracks FIFO occupancy from a gray-coded read count returned from the rd_clock domain.
//  - Never overflows the FIFO: a word is accepted only while at least one slot is free.
// PARAMETERS
//  - BIT_WIDTH  -1  Data word width; MUST be set (>= 1).
//  - FIFO_SIZE  -1  Depth of the attached fifo_dc; MUST be set (>= 2).
//  - BURST_LEN  16  Maximum words per grant; range [1, 65535].
//  - CNT_BITW = log2(FIFO_SIZE)+1 (localparam) is the wr/rd counter width.
// PORTS
//  - wr_clock       in   1          Write-domain clock.
//  - n_rst          in   1          Reset, synchronous, active-low.
//  - req0_valid     in   1          Requester 0 has a word.
//  - req0_data      in   BIT_WIDTH  Requester 0 word.
//  - req0_ready     out  1          Requester 0 word accepted when valid&ready.
//  - req1_valid     in   1          Requester 1 has a word.
//  - req1_data      in   BIT_WIDTH  Requester 1 word.
//  - req1_ready     out  1          Requester 1 word accepted when valid&ready.
//  - rd_count_gray  in   CNT_BITW   Gray-coded total words read, from rd_clock domain.
//  - fifo_wr_en     out  1          To fifo_dc wr_en.
//  - fifo_wr_data   out  BIT_WIDTH  To fifo_dc wr_data.
//  - occupancy      out  CNT_BITW   wr_cnt - rd_cnt_sync (conservative fill level).
//  - grant          out  2          One-hot current owner; 2'b00 in IDLE.
// BEHAVIOUR
//  - Reset (n_rst=0 at posedge): state=IDLE, last_grant=1, wr_cnt=0, sync regs=0, burst_cnt=0.
//    All outputs 0. Reset mid-burst aborts the burst; a word already registered on fifo_wr_* is dropped.
//  - Read-count sync:
//    - rd_count_gray passes through 2 flops, then gray->binary into a register.
//    - Result is rd_cnt_sync; a read becomes visible 3 wr_clock cycles after it.
//  - Free-slot rule: free = FIFO_SIZE - (wr_cnt - rd_cnt_sync), computed modulo 2^CNT_BITW.
//    - reqX_ready = (state==GNTX) && (free != 0).
//  - Accept: valid&ready at posedge.
//    - Registers data to fifo_wr_data with fifo_wr_en=1 the next cycle (latency 1).
//    - wr_cnt increments the same edge; wrap is natural at 2^CNT_BITW.
//    - fifo_wr_en=0 and fifo_wr_data holds its value on non-accept cycles.
//  - FSM states IDLE, GNT0, GNT1:
//    - IDLE: one valid -> grant that requester. Both valid -> grant the one != last_grant.
//      Neither valid -> stay. burst_cnt cleared on entry to GNTx; last_grant updated on entry.
//    - GNTx -> IDLE when either condition holds:
//      - an accept occurs with burst_cnt==BURST_LEN-1;
//      - reqX_valid==0 (requester released).
//    - GNTx with valid=1 and free=0: stall in GNTx; burst_cnt holds; the grant is not released.
//    - At least one IDLE cycle always separates grants (re-arbitration bubble).
//  - Simultaneous events:
//    - An accept and a read-count update on the same edge are both applied.
//    - free is based on the previous rd_cnt_sync, so it is never over-estimated.
//  - occupancy is registered from wr_cnt and rd_cnt_sync.
//  - FIFO empty: occupancy=0. FIFO full: occupancy=FIFO_SIZE and both ready=0.
// CONFIGURATION
//  - FIFO_ARB_FIXED_PRIO_EN defined: IDLE arbitration is fixed priority; req0 always wins when both are valid.
//    last_grant is unused.
//  - Undefined (default): round-robin as above.
// TESTING
//  - Reset, then req0_valid=1 only, rd_count static 0, FIFO_SIZE=8, BURST_LEN=4:
//    - grant=01 after 1 cycle; 4 accepts; IDLE 1 cycle; re-grant 01; 4 more accepts;
//    - then ready=0 and occupancy=8 held.
//  - Both valid continuously, fast reader, BURST_LEN=4: grants alternate 01,10,01...
//    Exactly 4 words each; first grant is req0.
//  - Fill FIFO_SIZE=8, then step rd_count_gray 0->1: req ready rises exactly 3 cycles later.
//    One accept, then ready=0 again; occupancy 8->7->8.
//  - req1 drops valid after 2 of 4 words: FSM returns to IDLE next edge; pending req0 is granted after the bubble.
//  - Wrap: run 3*2^CNT_BITW words through with a looping reader.
//    Occupancy never exceeds FIFO_SIZE; words arrive in order with none lost.
//  - Assert n_rst mid-burst: all outputs 0 next edge; after release, first grant goes to req0.
//    Repeat with FIFO_ARB_FIXED_PRIO_EN: req0 wins every contended IDLE.

Source files
------------

// File: rtl/fifo_dc_wr_arbiter.sv
// Write-side arbiter for a dual-clock FIFO: round-robin bursts, gray read sync.
// Ports: wr_clock, n_rst (sync, active-low), req0_*/req1_* valid/data/ready,
//   rd_count_gray (rd domain), fifo_wr_en/fifo_wr_data, occupancy, grant.
// Build option: define FIFO_ARB_FIXED_PRIO_EN for fixed priority (req0 wins).
module fifo_dc_wr_arbiter #(
  parameter int BIT_WIDTH = -1,
  parameter int FIFO_SIZE = -1,
  parameter int BURST_LEN = 16,
  localparam int CNT_BITW = $clog2(FIFO_SIZE) + 1
) (
  input  logic                 wr_clock,
  input  logic                 n_rst,
  input  logic                 req0_valid,
  input  logic [BIT_WIDTH-1:0] req0_data,
  output logic                 req0_ready,
  input  logic                 req1_valid,
  input  logic [BIT_WIDTH-1:0] req1_data,
  output logic                 req1_ready,
  input  logic [CNT_BITW-1:0]  rd_count_gray,
  output logic                 fifo_wr_en,
  output logic [BIT_WIDTH-1:0] fifo_wr_data,
  output logic [CNT_BITW-1:0]  occupancy,
  output logic [1:0]           grant
);

  localparam logic [CNT_BITW-1:0] SIZE_C = CNT_BITW'(FIFO_SIZE);
  localparam logic [15:0]         LAST_C = 16'(BURST_LEN - 1);

  typedef enum logic [1:0] {
    IDLE,
    GNT0,
    GNT1
  } state_t;

  state_t              state_q, state_d;
  logic [15:0]         burst_q, burst_d;
  logic [CNT_BITW-1:0] wr_cnt_q;
  logic [CNT_BITW-1:0] sync1_q, sync2_q;
  logic [CNT_BITW-1:0] rd_sync_q;
  logic [CNT_BITW-1:0] used;
  logic [CNT_BITW-1:0] free;
  logic                acc0, acc1, accept;
`ifndef FIFO_ARB_FIXED_PRIO_EN
  logic                last_q, last_d;
`endif

  function automatic logic [CNT_BITW-1:0] gray2bin(
    input logic [CNT_BITW-1:0] g
  );
    logic [CNT_BITW-1:0] b;
    for (int i = 0; i < CNT_BITW; i++)
      b[i] = ^(g >> i);
    return b;
  endfunction

  // Occupancy uses the synced read count, which lags the real
  // one, so free can only be under-estimated, never over.
  always_comb begin
    used       = wr_cnt_q - rd_sync_q;
    free       = SIZE_C - used;
    req0_ready = (state_q == GNT0) && (free != '0);
    req1_ready = (state_q == GNT1) && (free != '0);
    acc0       = req0_valid && req0_ready;
    acc1       = req1_valid && req1_ready;
    accept     = acc0 || acc1;
    grant      = {state_q == GNT1, state_q == GNT0};
  end

  always_comb begin
    state_d = state_q;
    burst_d = burst_q;
`ifndef FIFO_ARB_FIXED_PRIO_EN
    last_d  = last_q;
`endif
    unique case (state_q)
      IDLE: begin
`ifdef FIFO_ARB_FIXED_PRIO_EN
        if (req0_valid)
          state_d = GNT0;
        else if (req1_valid)
          state_d = GNT1;
`else
        if (req0_valid && req1_valid)
          state_d = last_q ? GNT0 : GNT1;
        else if (req0_valid)
          state_d = GNT0;
        else if (req1_valid)
          state_d = GNT1;
        if (state_d != IDLE)
          last_d = (state_d == GNT1);
`endif
        if (state_d != IDLE)
          burst_d = '0;
      end
      GNT0: begin
        if (!req0_valid)
          state_d = IDLE;
        else if (acc0) begin
          if (burst_q == LAST_C)
            state_d = IDLE;
          else
            burst_d = burst_q + 16'd1;
        end
      end
      GNT1: begin
        if (!req1_valid)
          state_d = IDLE;
        else if (acc1) begin
          if (burst_q == LAST_C)
            state_d = IDLE;
          else
            burst_d = burst_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge wr_clock) begin
    if (!n_rst) begin
      state_q      <= IDLE;
      burst_q      <= '0;
`ifndef FIFO_ARB_FIXED_PRIO_EN
      last_q       <= 1'b1;
`endif
      wr_cnt_q     <= '0;
      sync1_q      <= '0;
      sync2_q      <= '0;
      rd_sync_q    <= '0;
      occupancy    <= '0;
      fifo_wr_en   <= 1'b0;
      fifo_wr_data <= '0;
    end else begin
      state_q    <= state_d;
      burst_q    <= burst_d;
`ifndef FIFO_ARB_FIXED_PRIO_EN
      last_q     <= last_d;
`endif
      sync1_q    <= rd_count_gray;
      sync2_q    <= sync1_q;
      rd_sync_q  <= gray2bin(sync2_q);
      wr_cnt_q   <= wr_cnt_q + CNT_BITW'(accept);
      occupancy  <= used;
      fifo_wr_en <= accept;
      if (accept)
        fifo_wr_data <= acc1 ? req1_data : req0_data;
    end
  end

endmodule

// File: tb/tb_fifo_dc_wr_arbiter.sv
// Directed bench for fifo_dc_wr_arbiter (FIFO_SIZE=8, BURST_LEN=4).
// Define FIFO_ARB_FIXED_PRIO_EN to expect fixed-priority grants.
module tb_fifo_dc_wr_arbiter;

  localparam int BW = 8;
  localparam int FS = 8;
  localparam int BL = 4;
  localparam int CW = 4;

  logic          wr_clock;
  logic          n_rst;
  logic          req0_valid, req1_valid;
  logic [BW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic [CW-1:0] rd_count_gray;
  logic          fifo_wr_en;
  logic [BW-1:0] fifo_wr_data;
  logic [CW-1:0] occupancy;
  logic [1:0]    grant;

  int            errs;
  int            checks;
  int            n0, n1;
  logic [CW-1:0] rd_bin;
  bit            reader_on;

  fifo_dc_wr_arbiter #(
    .BIT_WIDTH(BW),
    .FIFO_SIZE(FS),
    .BURST_LEN(BL)
  ) dut (
    .wr_clock     (wr_clock),
    .n_rst        (n_rst),
    .req0_valid   (req0_valid),
    .req0_data    (req0_data),
    .req0_ready   (req0_ready),
    .req1_valid   (req1_valid),
    .req1_data    (req1_data),
    .req1_ready   (req1_ready),
    .rd_count_gray(rd_count_gray),
    .fifo_wr_en   (fifo_wr_en),
    .fifo_wr_data (fifo_wr_data),
    .occupancy    (occupancy),
    .grant        (grant)
  );

  initial wr_clock = 1'b0;
  always #5 wr_clock = ~wr_clock;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1);
  end

  task automatic tick();
    logic a0, a1;
    a0 = req0_valid && req0_ready;
    a1 = req1_valid && req1_ready;
    @(posedge wr_clock);
    #1;
    if (a0) n0++;
    if (a1) n1++;
    req0_data = BW'(n0);
    req1_data = BW'(n1 + 128);
    if (reader_on && fifo_wr_en) rd_bin++;
    rd_count_gray = rd_bin ^ (rd_bin >> 1);
  endtask

  task automatic do_reset();
    n_rst         = 1'b0;
    req0_valid    = 1'b0;
    req1_valid    = 1'b0;
    n0            = 0;
    n1            = 0;
    rd_bin        = '0;
    reader_on     = 1'b0;
    req0_data     = '0;
    req1_data     = 8'd128;
    rd_count_gray = '0;
    tick();
    tick();
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (grant !== 2'b00) begin
      errs++;
      $display("FAIL reset_grant: got %b want 00", grant);
    end
    checks++;
    if ({req0_ready, req1_ready} !== 2'b00) begin
      errs++;
      $display("FAIL reset_ready: got %b want 00",
               {req0_ready, req1_ready});
    end
    checks++;
    if (fifo_wr_en !== 1'b0 || fifo_wr_data !== '0) begin
      errs++;
      $display("FAIL reset_wr: got %b/%h want 0/00",
               fifo_wr_en, fifo_wr_data);
    end
    checks++;
    if (occupancy !== '0) begin
      errs++;
      $display("FAIL reset_occ: got %0d want 0", occupancy);
    end
  endtask

  // Two bursts of 4 with a bubble, then the FIFO is full.
  task automatic test_single_burst();
    logic [21:0] g_tab;
    logic [10:0] e_tab;
    int          k;
    g_tab = {2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 2'b01,
             2'b01, 2'b01, 2'b01, 2'b00, 2'b01};
    e_tab = 11'b01111011110;
    k = 0;
    do_reset();
    req0_valid = 1'b1;
    for (int i = 1; i <= 11; i++) begin
      tick();
      checks++;
      if (grant !== g_tab[2*(11-i)+:2]) begin
        errs++;
        $display("FAIL burst_grant E%0d: got %b want %b",
                 i, grant, g_tab[2*(11-i)+:2]);
      end
      checks++;
      if (fifo_wr_en !== e_tab[11-i]) begin
        errs++;
        $display("FAIL burst_wr_en E%0d: got %b want %b",
                 i, fifo_wr_en, e_tab[11-i]);
      end
      if (e_tab[11-i]) begin
        checks++;
        if (fifo_wr_data !== BW'(k)) begin
          errs++;
          $display("FAIL burst_data E%0d: got %h want %h",
                   i, fifo_wr_data, BW'(k));
        end
        k++;
      end
    end
    checks++;
    if (req0_ready !== 1'b0) begin
      errs++;
      $display("FAIL full_ready: got %b want 0", req0_ready);
    end
    tick();
    checks++;
    if (occupancy !== 4'd8 || req0_ready !== 1'b0) begin
      errs++;
      $display("FAIL full_occ: got %0d/%b want 8/0",
               occupancy, req0_ready);
    end
  endtask

  // Continues from full: one read frees exactly one slot.
  task automatic test_fill_read();
    logic [4:0] r_tab;
    logic [CW-1:0] o_tab [5];
    r_tab = 5'b00100;
    o_tab[0] = 4'd8;
    o_tab[1] = 4'd8;
    o_tab[2] = 4'd8;
    o_tab[3] = 4'd7;
    o_tab[4] = 4'd8;
    rd_bin = 4'd1;
    rd_count_gray = 4'd1;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (req0_ready !== r_tab[4-i]) begin
        errs++;
        $display("FAIL fill_ready +%0d: got %b want %b",
                 i + 1, req0_ready, r_tab[4-i]);
      end
      checks++;
      if (occupancy !== o_tab[i]) begin
        errs++;
        $display("FAIL fill_occ +%0d: got %0d want %0d",
                 i + 1, occupancy, o_tab[i]);
      end
      if (i == 3) begin
        checks++;
        if (fifo_wr_en !== 1'b1 || fifo_wr_data !== 8'd8) begin
          errs++;
          $display("FAIL fill_word: got %b/%h want 1/08",
                   fifo_wr_en, fifo_wr_data);
        end
      end
    end
    req0_valid = 1'b0;
  endtask

  task automatic test_round_robin();
    logic [29:0] g_tab;
    int          w0, w1;
`ifdef FIFO_ARB_FIXED_PRIO_EN
    g_tab = {2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
             2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
             2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    w0 = 12;
    w1 = 0;
`else
    g_tab = {2'b01, 2'b01, 2'b01, 2'b01, 2'b00,
             2'b10, 2'b10, 2'b10, 2'b10, 2'b00,
             2'b01, 2'b01, 2'b01, 2'b01, 2'b00};
    w0 = 8;
    w1 = 4;
`endif
    do_reset();
    reader_on  = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 1; i <= 15; i++) begin
      tick();
      checks++;
      if (grant !== g_tab[2*(15-i)+:2]) begin
        errs++;
        $display("FAIL rr_grant E%0d: got %b want %b",
                 i, grant, g_tab[2*(15-i)+:2]);
      end
    end
    checks++;
    if (n0 != w0 || n1 != w1) begin
      errs++;
      $display("FAIL rr_words: got %0d/%0d want %0d/%0d",
               n0, n1, w0, w1);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  task automatic test_release();
    do_reset();
    req1_valid = 1'b1;
    tick();
    tick();
    tick();
    checks++;
    if (grant !== 2'b10 || n1 != 2) begin
      errs++;
      $display("FAIL rel_pre: got %b/%0d want 10/2", grant, n1);
    end
    req1_valid = 1'b0;
    req0_valid = 1'b1;
    tick();
    checks++;
    if (grant !== 2'b00 || fifo_wr_en !== 1'b0) begin
      errs++;
      $display("FAIL rel_idle: got %b/%b want 00/0",
               grant, fifo_wr_en);
    end
    tick();
    checks++;
    if (grant !== 2'b01) begin
      errs++;
      $display("FAIL rel_regrant: got %b want 01", grant);
    end
    req0_valid = 1'b0;
  endtask

  task automatic test_wrap();
    int exp_w;
    exp_w = 0;
    do_reset();
    reader_on  = 1'b1;
    req0_valid = 1'b1;
    for (int c = 0; c < 400 && exp_w < 48; c++) begin
      tick();
      checks++;
      if (occupancy > CW'(FS)) begin
        errs++;
        $display("FAIL wrap_occ: got %0d want <= %0d",
                 occupancy, FS);
      end
      if (fifo_wr_en) begin
        checks++;
        if (fifo_wr_data !== BW'(exp_w)) begin
          errs++;
          $display("FAIL wrap_data #%0d: got %h want %h",
                   exp_w, fifo_wr_data, BW'(exp_w));
        end
        exp_w++;
      end
    end
    checks++;
    if (exp_w != 48) begin
      errs++;
      $display("FAIL wrap_count: got %0d want 48", exp_w);
    end
    req0_valid = 1'b0;
  endtask

  task automatic test_back_to_back_reset();
    do_reset();
    reader_on  = 1'b1;
    req0_valid = 1'b1;
    req1_valid = 1'b1;
    for (int i = 0; i < 7; i++) tick();
    checks++;
`ifdef FIFO_ARB_FIXED_PRIO_EN
    if (grant !== 2'b01) begin
      errs++;
      $display("FAIL mid_pre: got %b want 01", grant);
    end
`else
    if (grant !== 2'b10) begin
      errs++;
      $display("FAIL mid_pre: got %b want 10", grant);
    end
`endif
    n_rst     = 1'b0;
    reader_on = 1'b0;
    rd_bin    = '0;
    tick();
    checks++;
    if (grant !== 2'b00 || {req0_ready, req1_ready} !== 2'b00) begin
      errs++;
      $display("FAIL mid_rst_gr: got %b/%b want 00/00",
               grant, {req0_ready, req1_ready});
    end
    checks++;
    if (fifo_wr_en !== 1'b0 || fifo_wr_data !== '0 ||
        occupancy !== '0) begin
      errs++;
      $display("FAIL mid_rst_wr: got %b/%h/%0d want 0/00/0",
               fifo_wr_en, fifo_wr_data, occupancy);
    end
    n_rst = 1'b1;
    tick();
    checks++;
    if (grant !== 2'b01 || fifo_wr_en !== 1'b0) begin
      errs++;
      $display("FAIL mid_regrant: got %b/%b want 01/0",
               grant, fifo_wr_en);
    end
    req0_valid = 1'b0;
    req1_valid = 1'b0;
  endtask

  initial begin
    errs   = 0;
    checks = 0;
    test_reset();
    test_single_burst();
    test_fill_read();
    test_round_robin();
    test_release();
    test_wrap();
    test_back_to_back_reset();
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
